// File: rtl/riscv_types.sv
// rtl/riscv_types.sv - shared types and constants for the divider
// Contents: XLEN, div_op_t (DIV/DIVU/REM/REMU), div_state_t (IDLE/CALC/DONE).
package riscv_types;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response handshake bundle for div_unit
// Request:  in_valid, in_ready, div_op, op1, op2
// Response: out_valid, out_ready, result
// Control:  flush (kill in-flight op), busy (CALC or DONE)
interface div_unit_if;
    import riscv_types::*;

    logic            in_valid;
    logic            in_ready;
    div_op_t         div_op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            flush;
    logic            busy;

    modport master (
        output in_valid, div_op, op1, op2, out_ready, flush,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, div_op, op1, op2, out_ready, flush,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/n_bit_add_sub.sv
// rtl/n_bit_add_sub.sv - n-bit adder/subtractor, M=0 adds, M=1 subtracts
// Ports: a, b (n-bit operands), s (n-bit a+b or a-b, modulo 2^n)
module n_bit_add_sub #(
    parameter int n = 33,
    parameter bit M = 1'b1
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] s
);

    assign s = a + (b ^ {n{M}}) + n'(M);

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU)
// Ports: clk, reset (async, active-high), bus (div_unit_if.slave: request,
//        response and flush/busy). Optional result cache: DIV_RESULT_CACHE_EN.
module div_unit
    import riscv_types::*;
(
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]      state;
    logic [4:0]      count;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quo_sh;     // dividend bits shift out at the top, quotient bits in at the bottom
    logic [XLEN-1:0] rem;
    logic            neg_q;
    logic            neg_r;
    logic            want_rem;
    logic [XLEN-1:0] result_q;

    // request decode
    logic            in_signed;
    logic            in_rem;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            overflow;
    logic            hit;
    logic [XLEN-1:0] hit_val;

    assign in_signed = ~bus.div_op[0];
    assign in_rem    = bus.div_op[1];
    assign abs1      = (in_signed && bus.op1[XLEN-1]) ? -bus.op1 : bus.op1;
    assign abs2      = (in_signed && bus.op2[XLEN-1]) ? -bus.op2 : bus.op2;
    assign div_zero  = (bus.op2 == '0);
    assign overflow  = in_signed && (bus.op1 == 32'h8000_0000) && (bus.op2 == 32'hFFFF_FFFF);

    // one restoring iteration
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] next_rem;
    logic [XLEN-1:0] next_quo;
    logic [XLEN-1:0] fin_q;
    logic [XLEN-1:0] fin_r;
    logic            calc_last;

    assign shifted = {rem, quo_sh[XLEN-1]};

    n_bit_add_sub #(.n(XLEN + 1), .M(1'b1)) u_sub (
        .a (shifted),
        .b ({1'b0, divisor}),
        .s (diff)
    );

    // shifted < 2*divisor, so the difference fits in 32 bits when non-negative
    // and bit 32 is a clean sign bit when it is not.
    assign q_bit     = ~diff[XLEN];
    assign next_rem  = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign next_quo  = {quo_sh[XLEN-2:0], q_bit};
    assign fin_q     = neg_q ? -next_quo : next_quo;
    assign fin_r     = neg_r ? -next_rem : next_rem;
    assign calc_last = (state == ST_CALC) && (count == 5'd31) && !bus.flush;

`ifdef DIV_RESULT_CACHE_EN
    logic [XLEN-1:0] l_op1, l_op2;
    logic            l_signed;
    logic            c_valid;
    logic [XLEN-1:0] c_op1, c_op2, c_q, c_r;
    logic            c_signed;

    assign hit     = c_valid && (c_op1 == bus.op1) && (c_op2 == bus.op2) && (c_signed == in_signed);
    assign hit_val = in_rem ? c_r : c_q;

    // only completed CALC results are stored; a flush on the last cycle stores nothing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_op1    <= '0;
            l_op2    <= '0;
            l_signed <= 1'b0;
            c_valid  <= 1'b0;
            c_op1    <= '0;
            c_op2    <= '0;
            c_signed <= 1'b0;
            c_q      <= '0;
            c_r      <= '0;
        end else begin
            if (state == ST_IDLE && bus.in_valid && !bus.flush) begin
                l_op1    <= bus.op1;
                l_op2    <= bus.op2;
                l_signed <= in_signed;
            end
            if (calc_last) begin
                c_valid  <= 1'b1;
                c_op1    <= l_op1;
                c_op2    <= l_op2;
                c_signed <= l_signed;
                c_q      <= fin_q;
                c_r      <= fin_r;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_val = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            divisor  <= '0;
            quo_sh   <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            want_rem <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        want_rem <= in_rem;
                        if (div_zero) begin
                            result_q <= in_rem ? bus.op1 : '1;
                            state    <= ST_DONE;
                        end else if (overflow) begin
                            result_q <= in_rem ? '0 : 32'h8000_0000;
                            state    <= ST_DONE;
                        end else if (hit) begin
                            result_q <= hit_val;
                            state    <= ST_DONE;
                        end else begin
                            divisor <= abs2;
                            quo_sh  <= abs1;
                            rem     <= '0;
                            neg_q   <= in_signed && (bus.op1[XLEN-1] ^ bus.op2[XLEN-1]);
                            neg_r   <= in_signed && bus.op1[XLEN-1];
                            count   <= '0;
                            state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem    <= next_rem;
                    quo_sh <= next_quo;
                    count  <= count + 5'd1;
                    if (count == 5'd31) begin
                        result_q <= want_rem ? fin_r : fin_q;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
// Optional: DIV_RESULT_CACHE_EN changes the expected latency of repeated operands.
module tb_div_unit;
    import riscv_types::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_unit_if bus();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

`ifdef DIV_RESULT_CACHE_EN
    localparam int CL = 1;
`else
    localparam int CL = 33;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input div_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bus.div_op   = op;
        bus.op1      = a;
        bus.op2      = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.result, exp);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.div_op    = DIV;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_result",    bus.result,         32'd0);

        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, CL);
        run_op("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, CL);
        run_op("divu_5_0",   DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_5_0",    REM,  32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // flush in IDLE with a request present: not accepted
        bus.div_op   = DIVU;
        bus.op1      = 32'd9;
        bus.op2      = 32'd3;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("flush_idle_busy", 32'(bus.busy), 32'd0);

        // flush in cycle 10 of a DIV
        bus.div_op   = DIV;
        bus.op1      = 32'd1000;
        bus.op2      = 32'd3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_busy",     32'(bus.busy),     32'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) lat++;
            step();
        end
        chk("flush_no_valid", 32'(lat), 32'd0);

        run_op("div_1000_3",  DIV,  32'd1000, 32'd3, 32'd333, 33);
        run_op("rem_1000_3",  REM,  32'd1000, 32'd3, 32'd1, CL);
        run_op("divu_1000_3", DIVU, 32'd1000, 32'd3, 32'd333, 33);

        // hold out_ready low for 5 cycles in DONE
        bus.div_op   = DIVU;
        bus.op1      = 32'd12345;
        bus.op2      = 32'd10;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_done(lat);
        chk("hold_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid",    32'(bus.out_valid), 32'd1);
            chk("hold_result",   bus.result,         32'd1234);
            chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
            step();
        end

        // back-to-back: request presented during the output handshake
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.div_op    = DIVU;
        bus.op1       = 32'd77;
        bus.op2       = 32'd8;
        step();
        bus.out_ready = 1'b0;
        chk("bubble_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bubble_busy",     32'(bus.busy),     32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("b2b_busy",     32'(bus.busy),     32'd1);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd0);
        wait_done(lat);
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("b2b_res", bus.result, 32'd9);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // reset mid-operation
        bus.div_op   = DIVU;
        bus.op1      = 32'd100;
        bus.op2      = 32'd7;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",      32'(bus.busy),      32'd0);
        chk("mid_rst_result",    bus.result,         32'd0);
        step();
        reset = 1'b0;
        step();
        run_op("post_rst_divu", DIVU, 32'd100, 32'd7, 32'd14, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
